// File: rtl/seg_pkg.sv
// Shared types and the 7-segment hex table for the display scan decoder.
package seg_pkg;

   localparam int DEF_NUM_DIGITS = 8;

   typedef logic [6:0] seg_pattern_t;

   // Patterns are active-low gfedcba; any other pattern is a miss.
   function automatic logic [3:0] seg_to_hex(
      input  seg_pattern_t p,
      output logic         hit
   );
      hit = 1'b1;
      case (p)
         7'h40:   seg_to_hex = 4'h0;
         7'h79:   seg_to_hex = 4'h1;
         7'h24:   seg_to_hex = 4'h2;
         7'h30:   seg_to_hex = 4'h3;
         7'h19:   seg_to_hex = 4'h4;
         7'h12:   seg_to_hex = 4'h5;
         7'h02:   seg_to_hex = 4'h6;
         7'h78:   seg_to_hex = 4'h7;
         7'h00:   seg_to_hex = 4'h8;
         7'h10:   seg_to_hex = 4'h9;
         7'h08:   seg_to_hex = 4'hA;
         7'h03:   seg_to_hex = 4'hB;
         7'h46:   seg_to_hex = 4'hC;
         7'h21:   seg_to_hex = 4'hD;
         7'h06:   seg_to_hex = 4'hE;
         7'h0E:   seg_to_hex = 4'hF;
         default: begin
            hit        = 1'b0;
            seg_to_hex = 4'h0;
         end
      endcase
   endfunction

endpackage

// File: rtl/seg_stable_filter.sv
// Registers the display drive and strobes once per stable period.
module seg_stable_filter
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS    = DEF_NUM_DIGITS,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  seg_pattern_t          led_i,
   input  logic [NUM_DIGITS-1:0] seg_i,
   output logic                  cap_o,
   output seg_pattern_t          led_o,
   output logic [NUM_DIGITS-1:0] seg_o
);

   localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES - 1);

   seg_pattern_t          led_q;
   seg_pattern_t          prev_led_q;
   logic [NUM_DIGITS-1:0] seg_q;
   logic [NUM_DIGITS-1:0] prev_seg_q;
   logic [CW-1:0]         cnt_q;
   logic                  done_q;
   logic                  same;
   logic                  sat;

   assign same  = {led_q, seg_q} == {prev_led_q, prev_seg_q};
   assign sat   = cnt_q == CMAX;
   assign cap_o = sat & ~done_q;

   // The previous sample is the one already proven stable by the compare.
   assign led_o = prev_led_q;
   assign seg_o = prev_seg_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         led_q      <= '0;
         seg_q      <= '0;
         prev_led_q <= '0;
         prev_seg_q <= '0;
         cnt_q      <= '0;
         done_q     <= 1'b0;
      end else begin
         led_q      <= led_i;
         seg_q      <= seg_i;
         prev_led_q <= led_q;
         prev_seg_q <= seg_q;
         if (!same) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
         end else begin
            if (!sat) cnt_q <= cnt_q + CW'(1);
            if (cap_o) done_q <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// Rebuilds the hex digits shown on a scanned 7-segment display.
module seg_scan_decoder
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS    = DEF_NUM_DIGITS,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [6:0]              led,
   input  logic [NUM_DIGITS-1:0]   segment,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic [NUM_DIGITS-1:0]   digit_valid,
   output logic                    frame_done,
   output logic                    err
);

   localparam int IW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
   localparam int ZW = $clog2(NUM_DIGITS + 1);

   logic                         cap;
   seg_pattern_t                 stb_led;
   logic [NUM_DIGITS-1:0]        stb_seg;
   logic [ZW-1:0]                zero_cnt;
   logic [IW-1:0]                zero_idx;
   logic [3:0]                   hex;
   logic                         hit;

   logic [NUM_DIGITS-1:0][3:0]   digits_q, digits_d;
   logic [NUM_DIGITS-1:0]        valid_q, valid_d;
   logic [NUM_DIGITS-1:0]        seen_q, seen_d;
   logic                         fd_q, fd_d;
   logic                         err_q, err_d;

   seg_stable_filter #(
      .NUM_DIGITS    (NUM_DIGITS),
      .STABLE_CYCLES (STABLE_CYCLES)
   ) u_filter (
      .clk   (clk),
      .reset (reset),
      .led_i (led),
      .seg_i (segment),
      .cap_o (cap),
      .led_o (stb_led),
      .seg_o (stb_seg)
   );

   always_comb begin
      zero_cnt = '0;
      zero_idx = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (!stb_seg[i]) begin
            zero_cnt = zero_cnt + ZW'(1);
            zero_idx = IW'(i);
         end
      end
   end

   always_comb begin
      digits_d = digits_q;
      valid_d  = valid_q;
      seen_d   = seen_q;
      fd_d     = 1'b0;
      err_d    = 1'b0;
      hex      = seg_to_hex(stb_led, hit);
      if (cap) begin
         unique case (1'b1)
            (zero_cnt == '0): ;
            (zero_cnt == ZW'(1)): begin
               if (hit) begin
                  digits_d[zero_idx] = hex;
                  valid_d[zero_idx]  = 1'b1;
                  seen_d = seen_q | (NUM_DIGITS'(1) << zero_idx);
                  if (&seen_d) begin
                     fd_d   = 1'b1;
                     seen_d = '0;
                  end
               end else begin
                  err_d = 1'b1;
               end
            end
            default: err_d = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         digits_q <= '0;
         valid_q  <= '0;
         seen_q   <= '0;
         fd_q     <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         digits_q <= digits_d;
         valid_q  <= valid_d;
         seen_q   <= seen_d;
         fd_q     <= fd_d;
         err_q    <= err_d;
      end
   end

   assign digits      = digits_q;
   assign digit_valid = valid_q;
   assign frame_done  = fd_q;
   assign err         = err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed checks of the scan decoder: frames, glitches, errors, reset.
module tb_seg_scan_decoder;

   logic        clk;
   logic        reset;
   logic [6:0]  led;
   logic [7:0]  segment;
   logic [31:0] digits;
   logic [7:0]  digit_valid;
   logic        frame_done;
   logic        err;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int fd_cnt = 0;
   int err_cnt = 0;
   int fd_first = -1;
   int d0_cyc = -2;
   bit d0_seen = 0;
   int e0, f0;

   logic [6:0] enc [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };
   int t1 [8] = '{2, 0, 2, 2, 14, 14, 1, 6};

   seg_scan_decoder #(
      .NUM_DIGITS    (8),
      .STABLE_CYCLES (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .led         (led),
      .segment     (segment),
      .digits      (digits),
      .digit_valid (digit_valid),
      .frame_done  (frame_done),
      .err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      cyc++;
      if (frame_done) begin
         if (fd_cnt == 0) fd_first = cyc;
         fd_cnt++;
      end
      if (err) err_cnt++;
      if (reset && !d0_seen && digits[3:0] == 4'h6) begin
         d0_seen = 1;
         d0_cyc  = cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic hold(input logic [6:0] l, input logic [7:0] s,
                       input int n);
      led     = l;
      segment = s;
      repeat (n) @(negedge clk);
   endtask

   task automatic show(input int i, input int v, input int n);
      hold(enc[v], ~(8'(1) << i), n);
   endtask

   initial begin
      reset   = 1'b0;
      led     = 7'h7F;
      segment = 8'hFF;
      repeat (3) @(negedge clk);
      chk("rst_digits", digits, 32'h0);
      chk("rst_valid", {24'h0, digit_valid}, 32'h0);
      chk("rst_fd", {31'h0, frame_done}, 32'h0);
      chk("rst_err", {31'h0, err}, 32'h0);
      reset = 1'b1;

      for (int k = 0; k < 8; k++) show(7 - k, t1[k], 10);
      chk("f1_digits", digits, 32'h2022EE16);
      chk("f1_valid", {24'h0, digit_valid}, 32'hFF);
      chk("f1_fd_cnt", fd_cnt, 1);
      chk("f1_err_cnt", err_cnt, 0);
      chk("f1_fd_at_d0", fd_first, d0_cyc);

      e0 = err_cnt;
      f0 = fd_cnt;
      led     = enc[5];
      segment = ~8'h08;
      repeat (5) @(negedge clk);
      chk("lat_before", {28'h0, digits[15:12]}, 32'hE);
      @(negedge clk);
      chk("lat_after", {28'h0, digits[15:12]}, 32'h5);
      repeat (94) @(negedge clk);
      chk("hold_err", err_cnt - e0, 0);
      chk("hold_fd", fd_cnt - f0, 0);

      hold(enc[1], ~8'h08, 2);
      hold(7'h7F, 8'hFF, 10);
      chk("glitch_d3", {28'h0, digits[15:12]}, 32'h5);
      chk("glitch_err", err_cnt - e0, 0);

      e0 = err_cnt;
      hold(7'h40, 8'hF3, 10);
      hold(7'h7F, 8'hFF, 5);
      chk("multi_err", err_cnt - e0, 1);
      chk("multi_digits", digits, 32'h20225E16);

      e0 = err_cnt;
      hold(7'h7F, 8'hFE, 10);
      hold(7'h7F, 8'hFF, 5);
      chk("miss_err", err_cnt - e0, 1);
      chk("miss_digits", digits, 32'h20225E16);

      for (int k = 0; k < 5; k++) show(7 - k, k + 1, 10);
      chk("pre_rst_digits", digits, 32'h12345E16);
      led     = 7'h7F;
      segment = 8'hFF;
      reset   = 1'b0;
      @(negedge clk);
      chk("mid_rst_digits", digits, 32'h0);
      chk("mid_rst_valid", {24'h0, digit_valid}, 32'h0);
      repeat (2) @(negedge clk);
      chk("mid_rst_fd", {31'h0, frame_done}, 32'h0);
      chk("mid_rst_err", {31'h0, err}, 32'h0);
      reset = 1'b1;
      f0 = fd_cnt;
      show(0, 8, 10);
      chk("post_valid0", {24'h0, digit_valid}, 32'h01);
      for (int i = 1; i < 7; i++) show(i, 8 + i, 10);
      chk("post_fd_early", fd_cnt - f0, 0);
      show(7, 15, 10);
      chk("post_fd", fd_cnt - f0, 1);
      chk("post_digits", digits, 32'hFEDCBA98);
      chk("post_valid", {24'h0, digit_valid}, 32'hFF);

      e0 = err_cnt;
      f0 = fd_cnt;
      hold(7'h7F, 8'hFF, 50);
      chk("blank_digits", digits, 32'hFEDCBA98);
      chk("blank_err", err_cnt - e0, 0);
      chk("blank_fd", fd_cnt - f0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
